// File: rtl/spell_mem_pkg.sv
// Shared types and constants for the Spell memory-port initiator.
// Covers the FSM state encoding, bus widths and the default watchdog limit.
package spell_mem_pkg;

    localparam int SPELL_MEM_ADDR_W = 8;
    localparam int SPELL_MEM_DATA_W = 8;

    localparam logic [7:0] SPELL_MEM_DEFAULT_TIMEOUT = 8'd16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } spell_mem_state_e;

endpackage

// File: rtl/spell_mem_watchdog.sv
// Cycle counter that flags a hung responder once the count reaches the limit.
// A limit of zero disables the expiry; the counter saturates instead of wrapping.
module spell_mem_watchdog (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       count_en_i,
    input  logic [7:0] limit_i,
    output logic       expired_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Expiry fires in the cycle whose increment would make the count equal the limit.
    assign expired_o = count_en_i && (limit_i != 8'd0) &&
                       (({1'b0, count_q} + 9'd1) == {1'b0, limit_i});

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (count_en_i && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spell_mem_initiator.sv
// Bus-master side of the Spell memory port: one request at a time, strobe held
// through ACCESS until data_ready or watchdog expiry, then a single release cycle.
module spell_mem_initiator
    import spell_mem_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_CYCLES = SPELL_MEM_DEFAULT_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic                        req_data_space,
    input  logic [SPELL_MEM_ADDR_W-1:0] req_addr,
    input  logic [SPELL_MEM_DATA_W-1:0] req_wdata,
    output logic                        rsp_valid,
    output logic [SPELL_MEM_DATA_W-1:0] rsp_rdata,
    output logic                        rsp_error,
    output logic                        mem_select,
    output logic [SPELL_MEM_ADDR_W-1:0] mem_addr,
    output logic [SPELL_MEM_DATA_W-1:0] mem_data_in,
    output logic                        mem_memory_type_data,
    output logic                        mem_write,
    input  logic [SPELL_MEM_DATA_W-1:0] mem_data_out,
    input  logic                        mem_data_ready
);

    spell_mem_state_e state_q, state_d;

    logic                        mem_select_q, mem_select_d;
    logic [SPELL_MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [SPELL_MEM_DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic                        mem_type_q, mem_type_d;
    logic                        mem_write_q, mem_write_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [SPELL_MEM_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                        rsp_error_q, rsp_error_d;

    logic wd_clear;
    logic wd_count_en;
    logic wd_expired;
    logic req_fire;

    // A ready still high from the previous access must drop before a new select.
    assign req_ready = (state_q == IDLE) && !mem_data_ready;
    assign req_fire  = req_valid && req_ready;

    spell_mem_watchdog u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (wd_clear),
        .count_en_i (wd_count_en),
        .limit_i    (TIMEOUT_CYCLES),
        .expired_o  (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        mem_select_d  = mem_select_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        mem_type_d    = mem_type_q;
        mem_write_d   = mem_write_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = 1'b0;
        wd_clear      = 1'b0;
        wd_count_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    mem_addr_d    = req_addr;
                    mem_data_in_d = req_wdata;
                    mem_type_d    = req_data_space;
                    mem_write_d   = req_write;
                    mem_select_d  = 1'b1;
                    wd_clear      = 1'b1;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                wd_count_en = !mem_data_ready;
                // data_ready is checked first so it wins over a coincident expiry.
                if (mem_data_ready) begin
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = mem_write_q ? '0 : mem_data_out;
                    mem_select_d = 1'b0;
                    state_d      = RELEASE;
                end else if (wd_expired) begin
                    rsp_valid_d  = 1'b1;
                    rsp_error_d  = 1'b1;
                    rsp_rdata_d  = '0;
                    mem_select_d = 1'b0;
                    state_d      = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                mem_select_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mem_select_q  <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            mem_type_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_select_q  <= mem_select_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_type_q    <= mem_type_d;
            mem_write_q   <= mem_write_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
        end
    end

    assign mem_select           = mem_select_q;
    assign mem_addr             = mem_addr_q;
    assign mem_data_in          = mem_data_in_q;
    assign mem_memory_type_data = mem_type_q;
    assign mem_write            = mem_write_q;
    assign rsp_valid            = rsp_valid_q;
    assign rsp_rdata            = rsp_rdata_q;
    assign rsp_error            = rsp_error_q;

endmodule
